// File: rtl/mul_popcnt_pkg.sv
// Shared types, widths and helpers for the multiply/popcount arbiter slice.
package mul_popcnt_pkg;

  typedef enum logic [1:0] {IDLE, MULT, COUNT, RESP} state_t;

  localparam int RSP_W_WIDTH = 32;
  localparam int ONES_WIDTH  = 6;

  // Number of set bits in a 32-bit word (0..32).
  function automatic logic [ONES_WIDTH-1:0] popcount32(input logic [RSP_W_WIDTH-1:0] v);
    logic [ONES_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < RSP_W_WIDTH; i++) n = n + ONES_WIDTH'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mul_popcnt_core.sv
// Iterative shift-add multiplier with popcount of the low 32 product bits.
// One multiplier bit per cycle, LSB first, exactly OPW cycles after start.
module mul_popcnt_core
  import mul_popcnt_pkg::*;
#(
  parameter int OPW = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OPW-1:0]        a1,
  input  logic [OPW-1:0]        a2,
  output logic                  done,
  output logic [2*OPW-1:0]      product,
  output logic [ONES_WIDTH-1:0] ones
);

  logic [2*OPW-1:0] r_mcand;
  logic [OPW-1:0]   r_mplier;
  logic [2*OPW-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic             r_run;
  logic             w_last;

  // done marks the cycle whose edge performs the final accumulate
  assign w_last  = r_run && (r_cnt == 5'(OPW-1));
  assign done    = w_last;
  assign product = r_acc;
  assign ones    = popcount32(r_acc[RSP_W_WIDTH-1:0]);

  // Shift-add: acc += a1<<k when a2[k]; multiplicand shifts left, multiplier right
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{OPW{1'b0}}, a1};
      r_mplier <= a2;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_popcnt_arbiter.sv
// Round-robin arbiter in front of one shared multiply/popcount engine.
// Build option: MULARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module mul_popcnt_arbiter
  import mul_popcnt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OPW  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*OPW-1:0]   req_a1,
  input  logic [NREQ*OPW-1:0]   req_a2,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_id,
  output logic [RSP_W_WIDTH-1:0] rsp_w,
  output logic [ONES_WIDTH-1:0] rsp_ones,
  output logic                  rsp_ovf,
  output logic                  busy,
  output logic [15:0]           op_count
);

  localparam int PW = $clog2(NREQ);

  state_t                r_state, w_next;
  logic [PW-1:0]         w_ptr, w_win, r_id;
  logic [NREQ-1:0]       w_grant;
  logic                  w_any, w_hs, w_done;
  logic [OPW-1:0]        w_a1, w_a2;
  logic [2*OPW-1:0]      w_product;
  logic [ONES_WIDTH-1:0] w_ones;

  logic                  r_rsp_valid;
  logic [2:0]            r_rsp_id;
  logic [RSP_W_WIDTH-1:0] r_rsp_w;
  logic [ONES_WIDTH-1:0] r_rsp_ones;
  logic                  r_rsp_ovf;
  logic [15:0]           r_op_count;

`ifdef MULARB_FIXED_PRIO_EN
  // Fixed priority: search always starts at requester 0
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_rr_ptr;

  // Rotate priority to just past the last winner
  always_ff @(posedge clk) begin
    if (reset)     r_rr_ptr <= '0;
    else if (w_hs) r_rr_ptr <= (w_win == PW'(NREQ-1)) ? '0 : w_win + PW'(1);
  end

  assign w_ptr = r_rr_ptr;
`endif

  // First valid requester at or after w_ptr, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(w_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req_valid[idx]) begin
        w_grant[idx] = 1'b1;
        w_win        = PW'(idx);
        w_any        = 1'b1;
      end
    end
  end

  assign w_hs = (r_state == IDLE) && w_any;
  assign w_a1 = req_a1[w_win*OPW +: OPW];
  assign w_a2 = req_a2[w_win*OPW +: OPW];

  mul_popcnt_core #(.OPW(OPW)) u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (w_hs),
    .a1      (w_a1),
    .a2      (w_a2),
    .done    (w_done),
    .product (w_product),
    .ones    (w_ones)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs)      w_next = MULT;
      MULT:    if (w_done)    w_next = COUNT;
      COUNT:                  w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // FSM outputs: grants only offered while idle
  always_comb begin
    req_ready = '0;
    busy      = (r_state != IDLE);
    if (r_state == IDLE) req_ready = w_grant;
  end

  // Owner id, response capture and completed-op counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_w     <= '0;
      r_rsp_ones  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_hs) r_id <= w_win;
      if (r_state == COUNT) begin
        r_rsp_w     <= w_product[RSP_W_WIDTH-1:0];
        r_rsp_ones  <= w_ones;
        r_rsp_ovf   <= |w_product[2*OPW-1:RSP_W_WIDTH];
        r_rsp_id    <= 3'(r_id);
        r_rsp_valid <= 1'b1;
      end
      if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + 16'd1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_w     = r_rsp_w;
  assign rsp_ones  = r_rsp_ones;
  assign rsp_ovf   = r_rsp_ovf;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_mul_popcnt_arbiter.sv
// Scoreboard bench for mul_popcnt_arbiter (NREQ=4, OPW=24).
// Build option: MULARB_FIXED_PRIO_EN changes the expected grant order.
module tb_mul_popcnt_arbiter;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] w;
    logic [5:0]  ones;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [95:0] req_a1 = '0, req_a2 = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [2:0]  rsp_id;
  logic [31:0] rsp_w;
  logic [5:0]  rsp_ones;
  logic        rsp_ovf, busy;
  logic [15:0] op_count;

  int   errors = 0, checks = 0, cyc = 0;
  exp_t q[$];
  int   grant_log[$];

  mul_popcnt_arbiter #(.NREQ(4), .OPW(24)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a1(req_a1), .req_a2(req_a2),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_w(rsp_w), .rsp_ones(rsp_ones), .rsp_ovf(rsp_ovf), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // On every grant, push the reference result for the granted operands
  always @(negedge clk) begin : watch
    logic [47:0] p;
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          p = 48'(req_a1[i*24 +: 24]) * 48'(req_a2[i*24 +: 24]);
          e.id = 3'(i); e.w = p[31:0]; e.ones = 6'($countones(p[31:0])); e.ovf = |p[47:32];
          q.push_back(e);
          grant_log.push_back(i);
        end
      end
    end
  end

  // Pop and compare whenever a response is accepted
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got id=%0d w=%h", rsp_id, rsp_w);
      end else begin
        e = q.pop_front();
        if ({rsp_id, rsp_w, rsp_ones, rsp_ovf} !== {e.id, e.w, e.ones, e.ovf}) begin
          errors++;
          $display("FAIL scoreboard got id=%0d w=%h ones=%0d ovf=%b need id=%0d w=%h ones=%0d ovf=%b",
                   rsp_id, rsp_w, rsp_ones, rsp_ovf, e.id, e.w, e.ones, e.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
    req_a1[i*24 +: 24] = a;
    req_a2[i*24 +: 24] = b;
  endtask

  // Called at posedge+1; returns at posedge+1 after the grant, t = handshake cycle
  task automatic issue(input int i, input logic [23:0] a, input logic [23:0] b, output int t);
    bit ok;
    ok = 0; t = 0;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; t = cyc; end
    end
    if (!ok) begin errors++; checks++; $display("FAIL grant_timeout req=%0d", i); end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen high
  task automatic wait_rsp(output int t);
    bit ok;
    ok = 0; t = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; t = cyc; end
    end
    if (!ok) begin errors++; checks++; $display("FAIL rsp_timeout"); end
  endtask

  initial begin : stim
    int t0, t1;
    bit seen, stable, rdy0, ocsame;
    logic [42:0] snap;
    logic [15:0] oc;
    int exp_g[6];

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf, busy}, '0);
    chk("rst_op_count", op_count, 16'd0);
    @(posedge clk); #1;

    // 1: 3*5 with latency check
    issue(0, 24'd3, 24'd5, t0);
    wait_rsp(t1);
    chk("t1_latency", 64'(t1 - t0), 64'd26);
    chk("t1_result", {rsp_id, rsp_w, rsp_ones, rsp_ovf}, {3'd0, 32'd15, 6'd4, 1'b0});
    chk("t1_busy", busy, 1'b1);
    @(posedge clk); #1;

    // 2: max operands, overflow
    issue(1, 24'hFFFFFF, 24'hFFFFFF, t0);
    wait_rsp(t1);
    chk("t2_result", {rsp_id, rsp_w, rsp_ones, rsp_ovf}, {3'd1, 32'hFE000001, 6'd8, 1'b1});
    @(posedge clk); #1;

    // Zero operand still runs the full iteration count
    issue(3, 24'd0, 24'hABCDEF, t0);
    wait_rsp(t1);
    chk("zero_latency", 64'(t1 - t0), 64'd26);
    chk("zero_result", {rsp_w, rsp_ones, rsp_ovf}, {32'd0, 6'd0, 1'b0});
    @(posedge clk); #1;

    // 4: back-pressure in RESP
    rsp_ready = 1'b0;
    issue(2, 24'h123, 24'h10, t0);
    wait_rsp(t1);
    snap = {rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf};
    oc = op_count;
    chk("t4_result", {rsp_id, rsp_w}, {3'd2, 32'h1230});
    @(posedge clk); #1;
    set_op(3, 24'd1, 24'd1);
    req_valid[3] = 1'b1;
    stable = 1; rdy0 = 1; ocsame = 1;
    repeat (10) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf} !== snap) stable = 0;
      if (req_ready !== 4'b0) rdy0 = 0;
      if (op_count !== oc) ocsame = 0;
    end
    chk("t4_stable", stable, 1'b1);
    chk("t4_no_grant", rdy0, 1'b1);
    chk("t4_count_held", ocsame, 1'b1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_count_inc", op_count, 16'(oc + 16'd1));
    chk("t4_valid_clr", rsp_valid, 1'b0);
    @(posedge clk); #1;

    // 5: reset during MULT cycle 12 aborts the operation
    issue(0, 24'd7, 24'd9, t0);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_rst", {busy, op_count}, 17'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("t5_no_rsp", seen, 1'b0);
    @(posedge clk); #1;
    issue(2, 24'h1000, 24'h1000, t0);
    wait_rsp(t1);
    chk("t5_result", {rsp_w, rsp_ones, rsp_ovf}, {32'h01000000, 6'd1, 1'b0});
    @(posedge clk); #1;

    // 3: all requesters valid from reset
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 24'(i + 1), 24'(16 + i));
    req_valid = 4'hF;
    q.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 400 && grant_log.size() < 6; n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'h0;
    chk("t3_grant_count_ge6", 64'(grant_log.size() >= 6), 64'd1);
`ifdef MULARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0, 1};
`endif
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) chk($sformatf("t3_grant%0d", k), 64'(grant_log[k]), 64'(exp_g[k]));
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk("t3_drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1;

    // 6: op_count wrap
    force dut.r_op_count = 16'hFFFF;
    #2 release dut.r_op_count;
    @(negedge clk);
    chk("t6_preload", op_count, 16'hFFFF);
    @(posedge clk); #1;
    issue(1, 24'd2, 24'd3, t0);
    wait_rsp(t1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_wrap", op_count, 16'h0000);

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
